// File: rtl/updown_accum_4bit.sv
// Up/down accumulator with load, carry-out and signed-overflow flags.
// Handshaked on both sides: one command per accept/exec/result cycle.
module updown_accum_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             ld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             accept;
  logic [WIDTH-1:0] b_p0;
  logic             m_p0;
  logic             ld_p0;
  logic [WIDTH+1:0] alu_p1;

  // Returns {ovf, cout, sum}. Subtract is acc + ~b + 1, so cout=1 means no borrow.
  function automatic logic [WIDTH+1:0] alu_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] opnd_b,
    input logic             add,
    input logic             load
  );
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic             of;
    opnd = add ? opnd_b : ~opnd_b;
    sum  = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, ~add};
    of   = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    if (load) begin
      return {2'b00, opnd_b};
    end
    return {of, sum};
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == RESULT);
  assign accept    = in_valid && in_ready;
  assign alu_p1    = alu_calc(acc, b_p0, m_p0, ld_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESULT;
      RESULT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: command capture, only on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      b_p0  <= b;
      m_p0  <= m;
      ld_p0 <= ld;
    end
  end

  // Stage p1: architectural result, written only in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == EXEC) begin
      acc  <= alu_p1[WIDTH-1:0];
      cout <= alu_p1[WIDTH];
      ovf  <= alu_p1[WIDTH+1];
    end
  end

endmodule

// File: tb/tb_updown_accum_4bit.sv
// Directed bench for updown_accum_4bit: inputs driven and outputs sampled on the falling edge.
module tb_updown_accum_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] b;
  logic       m;
  logic       ld;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] acc;
  logic       cout;
  logic       ovf;

  int n_chk  = 0;
  int n_pass = 0;

  updown_accum_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b         (b),
    .m         (m),
    .ld        (ld),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [3:0] e_acc, input logic e_cout,
                           input logic e_ovf);
    check({tag, ".acc"},  8'(acc),  8'(e_acc));
    check({tag, ".cout"}, 8'(cout), 8'(e_cout));
    check({tag, ".ovf"},  8'(ovf),  8'(e_ovf));
  endtask

  // Waits (bounded) for in_ready, presents one command, and follows it to RESULT.
  task automatic accept_exec(input string tag, input logic ld_v, input logic m_v,
                             input logic [3:0] b_v);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".in_ready"}, 8'(in_ready), 8'h01);
    in_valid = 1'b1;
    ld = ld_v;
    m  = m_v;
    b  = b_v;
    @(negedge clk);
    in_valid = 1'b0;
    ld = ~ld_v;
    m  = ~m_v;
    b  = ~b_v;
    check({tag, ".vld_exec"}, 8'(out_valid), 8'h00);
    @(negedge clk);
    check({tag, ".vld_res"}, 8'(out_valid), 8'h01);
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".vld_done"}, 8'(out_valid), 8'h00);
  endtask

  task automatic run_op(input string tag, input logic ld_v, input logic m_v, input logic [3:0] b_v,
                        input logic [3:0] e_acc, input logic e_cout, input logic e_ovf);
    accept_exec(tag, ld_v, m_v, b_v);
    check_res(tag, e_acc, e_cout, e_ovf);
    complete(tag);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    b = 4'h0;
    m = 1'b0;
    ld = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check_res("rst0", 4'h0, 1'b0, 1'b0);
    check("rst0.out_valid", 8'(out_valid), 8'h00);
    check("rst0.in_ready", 8'(in_ready), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst0.ready_rel", 8'(in_ready), 8'h01);
    @(negedge clk);

    run_op("load5", 1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0);
    run_op("add3",  1'b0, 1'b1, 4'b0011, 4'b1000, 1'b0, 1'b1);
    run_op("load3", 1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);
    run_op("sub5b", 1'b0, 1'b0, 4'b0101, 4'b1110, 1'b0, 1'b0);
    run_op("load5b",1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0);
    run_op("sub5z", 1'b0, 1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0);
    run_op("loadF", 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    run_op("wrapup",1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0);
    run_op("load8", 1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0);
    run_op("wrapdn",1'b0, 1'b0, 4'b0001, 4'b0111, 1'b1, 1'b1);
    run_op("add1",  1'b0, 1'b1, 4'b0001, 4'b1000, 1'b0, 1'b1);

    // Backpressure: result held, new commands refused
    accept_exec("bp", 1'b1, 1'b0, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ld = i[0];
      m  = 1'b1;
      b  = 4'b1001 ^ 4'(i);
      @(negedge clk);
      check("bp.out_valid", 8'(out_valid), 8'h01);
      check("bp.in_ready", 8'(in_ready), 8'h00);
      check_res("bp", 4'b0110, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    complete("bp");
    check("bp.ready_after", 8'(in_ready), 8'h01);
    @(negedge clk);
    check("bp.no_cmd", 8'(out_valid), 8'h00);
    check_res("bp.idle", 4'b0110, 1'b0, 1'b0);
    run_op("bp.next", 1'b0, 1'b1, 4'b0001, 4'b0111, 1'b0, 1'b0);

    // Mid-cycle reset with a non-zero accumulator
    #2 rst = 1'b1;
    #1;
    check_res("rst1", 4'h0, 1'b0, 1'b0);
    check("rst1.in_ready", 8'(in_ready), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst1.ready_rel", 8'(in_ready), 8'h01);
    @(negedge clk);

    // Reset while in EXEC discards the command
    run_op("load3e", 1'b1, 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0);
    in_valid = 1'b1;
    ld = 1'b0;
    m  = 1'b1;
    b  = 4'b0100;
    @(negedge clk);
    in_valid = 1'b0;
    check("rexe.in_exec", 8'(out_valid), 8'h00);
    check("rexe.busy", 8'(in_ready), 8'h00);
    rst = 1'b1;
    #1;
    check_res("rexe", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rexe.ready_rel", 8'(in_ready), 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rexe.no_vld", 8'(out_valid), 8'h00);
      check("rexe.acc_hold", 8'(acc), 8'h00);
    end
    run_op("loadA", 1'b1, 1'b0, 4'b1010, 4'b1010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
